dahb_lsu: RTL and testbench
===========================

# dahb_lsu

Core-side load/store front end for the data AHB master interface. Accepts one load or store at a time from the execute stage, checks alignment, and replicates store data across byte lanes. Drives the `DAHB_*` request pins of the data AHB master interface, stalling while that block's transaction buffer is full. For loads, waits for the returned read data, then extracts the addressed lane and sign- or zero-extends it for register writeback.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width; equals `` `ADDR_WIDTH ``
- `DATA_WIDTH`, 32, data width; equals `` `DATA_WIDTH ``; only 32 supported

Ports:
- `cpu_clk`  in  1  the only clock; the data AHB master interface also runs on `cpu_clk` (sync configuration)
- `cpu_rst`  in  1  synchronous, active-high reset
- `mem_req`  in  1  request valid from execute; sampled only when `mem_stall`=0
- `mem_we`  in  1  0 load, 1 store
- `mem_size`  in  2  0 byte, 1 half, 2 word; 3 is reserved and treated as word
- `mem_unsigned`  in  1  load zero-extend (1) or sign-extend (0)
- `mem_addr`  in  ADDR_WIDTH  byte address
- `mem_wdata`  in  DATA_WIDTH  store data, right-justified
- `mem_rd`  in  5  load destination register index
- `mem_stall`  out  1  block busy; execute must hold
- `misalign_exc`  out  1  one-cycle pulse, misaligned request rejected
- `exc_addr`  out  ADDR_WIDTH  faulting address, held until next exception
- `ld_wb_valid`  out  1  one-cycle pulse, load result valid
- `ld_wb_rd`  out  5  destination index accompanying `ld_wb_valid`
- `ld_wb_data`  out  DATA_WIDTH  extended load result
- `DAHB_access`  out  1  one-cycle request to the transaction buffer
- `DAHB_size`  out  3  HSIZE encoding: 000 byte, 001 half, 010 word
- `DAHB_rd0_wr1`  out  1  read 0 / write 1
- `DAHB_addr`  out  ADDR_WIDTH  full byte address, not lane-masked
- `DAHB_write_data`  out  DATA_WIDTH  lane-replicated store data
- `DAHB_trans_buffer_full`  in  1  transaction buffer cannot accept this cycle
- `DAHB_read_data`  in  DATA_WIDTH  raw 32-bit HRDATA word
- `DAHB_read_data_valid`  in  1  one-cycle pulse, read data valid

## Operation
- FSM with three states:
  - IDLE: waits for `mem_req`.
  - ISSUE: presents the registered request to the buffer.
  - WAIT_RD: waits for load data.
- `mem_stall` = (state != IDLE). It is decoded from registered state, so it does not depend on `mem_req`.
- Alignment rule: a half with `addr[0]`=1 is misaligned; a word with `addr[1:0]`!=0 is misaligned.
- IDLE, `mem_req`=1, misaligned:
  - next cycle `misalign_exc`=1 and `exc_addr`=`mem_addr`;
  - no DAHB access is made; state stays IDLE.
- IDLE, `mem_req`=1, aligned: latch we/size/unsigned/addr/wdata/rd into request registers, then go to ISSUE.
- ISSUE: `DAHB_access` = !`DAHB_trans_buffer_full`. The `DAHB_*` fields are driven from the request registers in every state.
  - Full: stay in ISSUE and retry every cycle.
  - Not full, store: go to IDLE (store is posted).
  - Not full, load: go to WAIT_RD.
- Store lane replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- WAIT_RD, on `DAHB_read_data_valid`: register the extended result and go to IDLE. On the next cycle `ld_wb_valid`=1 with `ld_wb_rd`=latched rd.
- Load lane extraction, using the latched `addr[1:0]`:
  - byte: lane = `addr[1:0]`
  - half: lane = `addr[1]`
  - The lane is right-justified, then sign- or zero-extended to 32 bits.
- `DAHB_read_data_valid` outside WAIT_RD is ignored.
- The transaction buffer is FIFO-ordered, so a load issued after posted stores returns after them. No extra ordering logic is needed.

## Timing
- Reset values:
  - state IDLE;
  - `mem_stall`, `misalign_exc`, `ld_wb_valid`, `DAHB_access`, `DAHB_rd0_wr1` all 0;
  - `DAHB_size`=000;
  - `DAHB_addr`, `DAHB_write_data`, `exc_addr`, `ld_wb_data`, `ld_wb_rd` all 0.
- Reset mid-operation: return to IDLE immediately.
  - No `DAHB_access` is issued in the reset cycle or the cycle after it.
  - Any pending load result is discarded; a later read-valid pulse is ignored.
- Store, buffer not full: accept at T, `DAHB_access` at T+1, `mem_stall` high only at T+1. A new request is accepted at T+2.
- Load: accept at T, `DAHB_access` at T+1. If `DAHB_read_data_valid` arrives at cycle R, then `ld_wb_valid` is at R+1 and `mem_stall` is low at R+1.
- Full for N cycles: `DAHB_access` rises in the first cycle with full=0. It is asserted exactly once per request.
- Read-valid in the same cycle as `DAHB_access`: impossible; the data AHB master interface needs at least an address phase. The bench asserts this never occurs.
- Misalign: `mem_stall` is never raised; the exception pulse is at T+1.

## Test plan
- Store byte, addr 0x1003, wdata 0x000000A5, buffer not full -> T+1: access=1, size=000, wr=1, addr=0x1003, data=0xA5A5A5A5. Next request is accepted at T+2.
- Load half signed, addr 0x2002, read data 0x8001_1234 at R -> `ld_wb_data`=0xFFFF8001 at R+1. Repeat with `mem_unsigned`=1 -> 0x00008001.
- Load byte unsigned, addr 0x3001, data 0x11223344 -> `ld_wb_data`=0x00000033. `ld_wb_rd` equals the issued `mem_rd`.
- Buffer full for 5 cycles on a word store to 0x4000 -> `DAHB_access` held 0 for 5 cycles, then a single pulse. `mem_stall` is high throughout.
- Word load at 0x5002 -> `misalign_exc` pulse at T+1 with `exc_addr`=0x5002; no `DAHB_access`; a subsequent aligned load is accepted normally.
- `cpu_rst` asserted while in WAIT_RD, then read-valid pulsed after reset release -> no `ld_wb_valid`, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/dahb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : dahb_lsu
// Description : Core-side load/store front end for the data AHB master
//               interface. Accepts one load or store at a time, rejects
//               misaligned requests, replicates store data across byte
//               lanes, issues the request to the transaction buffer and, for
//               loads, extracts and extends the returned lane.
// Ports       : cpu_clk/cpu_rst      - clock, synchronous active-high reset
//               mem_*                - request from execute, mem_stall back
//               misalign_exc/exc_addr- alignment exception pulse + address
//               ld_wb_*              - load writeback pulse, index and data
//               DAHB_*               - data AHB master interface pins
// Revision    : 1.0 - initial release
// ============================================================================
module dahb_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_rst,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [1:0]            mem_size,
   input  logic                  mem_unsigned,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [4:0]            mem_rd,
   output logic                  mem_stall,
   output logic                  misalign_exc,
   output logic [ADDR_WIDTH-1:0] exc_addr,
   output logic                  ld_wb_valid,
   output logic [4:0]            ld_wb_rd,
   output logic [DATA_WIDTH-1:0] ld_wb_data,
   output logic                  DAHB_access,
   output logic [2:0]            DAHB_size,
   output logic                  DAHB_rd0_wr1,
   output logic [ADDR_WIDTH-1:0] DAHB_addr,
   output logic [DATA_WIDTH-1:0] DAHB_write_data,
   input  logic                  DAHB_trans_buffer_full,
   input  logic [DATA_WIDTH-1:0] DAHB_read_data,
   input  logic                  DAHB_read_data_valid
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [2:0]              hsize_q, hsize_d;   // request size, already HSIZE-encoded
   logic                    uns_q, uns_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;   // already lane-replicated
   logic [4:0]              rd_q, rd_d;
   logic                    misalign_exc_q, misalign_exc_d;
   logic [ADDR_WIDTH-1:0]   exc_addr_q, exc_addr_d;
   logic                    ld_wb_valid_q, ld_wb_valid_d;
   logic [4:0]              ld_wb_rd_q, ld_wb_rd_d;
   logic [DATA_WIDTH-1:0]   ld_wb_data_q, ld_wb_data_d;

   logic                    w_misaligned;
   logic [2:0]              w_hsize;
   logic [DATA_WIDTH-1:0]   w_repl;
   logic [7:0]              w_byte;
   logic [15:0]             w_half;
   logic [DATA_WIDTH-1:0]   w_ld_ext;

   // Reserved size 3 collapses to word, so it aligns and transfers as a word.
   always_comb begin
      w_hsize = 3'b010;
      w_repl  = mem_wdata;
      case (mem_size)
         2'd0: begin
            w_hsize = 3'b000;
            w_repl  = {4{mem_wdata[7:0]}};
         end
         2'd1: begin
            w_hsize = 3'b001;
            w_repl  = {2{mem_wdata[15:0]}};
         end
         default: begin
            w_hsize = 3'b010;
            w_repl  = mem_wdata;
         end
      endcase
   end

   assign w_misaligned = ((w_hsize == 3'b001) && mem_addr[0]) ||
                         ((w_hsize == 3'b010) && (mem_addr[1:0] != 2'b00));

   // Lane extraction from the raw HRDATA word using the latched address.
   always_comb begin
      w_byte = DAHB_read_data[7:0];
      case (addr_q[1:0])
         2'd0: w_byte = DAHB_read_data[7:0];
         2'd1: w_byte = DAHB_read_data[15:8];
         2'd2: w_byte = DAHB_read_data[23:16];
         default: w_byte = DAHB_read_data[31:24];
      endcase
      w_half = addr_q[1] ? DAHB_read_data[31:16] : DAHB_read_data[15:0];
      case (hsize_q)
         3'b000:  w_ld_ext = {{24{~uns_q & w_byte[7]}}, w_byte};
         3'b001:  w_ld_ext = {{16{~uns_q & w_half[15]}}, w_half};
         default: w_ld_ext = DAHB_read_data;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      we_d           = we_q;
      hsize_d        = hsize_q;
      uns_d          = uns_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rd_d           = rd_q;
      misalign_exc_d = 1'b0;
      exc_addr_d     = exc_addr_q;
      ld_wb_valid_d  = 1'b0;
      ld_wb_rd_d     = ld_wb_rd_q;
      ld_wb_data_d   = ld_wb_data_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_req) begin
               if (w_misaligned) begin
                  misalign_exc_d = 1'b1;
                  exc_addr_d     = mem_addr;
               end else begin
                  we_d    = mem_we;
                  hsize_d = w_hsize;
                  uns_d   = mem_unsigned;
                  addr_d  = mem_addr;
                  wdata_d = w_repl;
                  rd_d    = mem_rd;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            // Stores are posted; loads wait for the returned data.
            if (!DAHB_trans_buffer_full) begin
               state_d = we_q ? ST_IDLE : ST_WAIT_RD;
            end
         end
         ST_WAIT_RD: begin
            if (DAHB_read_data_valid) begin
               ld_wb_valid_d = 1'b1;
               ld_wb_rd_d    = rd_q;
               ld_wb_data_d  = w_ld_ext;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q        <= ST_IDLE;
         we_q           <= 1'b0;
         hsize_q        <= 3'b000;
         uns_q          <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         rd_q           <= 5'd0;
         misalign_exc_q <= 1'b0;
         exc_addr_q     <= '0;
         ld_wb_valid_q  <= 1'b0;
         ld_wb_rd_q     <= 5'd0;
         ld_wb_data_q   <= '0;
      end else begin
         state_q        <= state_d;
         we_q           <= we_d;
         hsize_q        <= hsize_d;
         uns_q          <= uns_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         rd_q           <= rd_d;
         misalign_exc_q <= misalign_exc_d;
         exc_addr_q     <= exc_addr_d;
         ld_wb_valid_q  <= ld_wb_valid_d;
         ld_wb_rd_q     <= ld_wb_rd_d;
         ld_wb_data_q   <= ld_wb_data_d;
      end
   end

   assign mem_stall       = (state_q != ST_IDLE);
   assign misalign_exc    = misalign_exc_q;
   assign exc_addr        = exc_addr_q;
   assign ld_wb_valid     = ld_wb_valid_q;
   assign ld_wb_rd        = ld_wb_rd_q;
   assign ld_wb_data      = ld_wb_data_q;
   assign DAHB_access     = (state_q == ST_ISSUE) && !DAHB_trans_buffer_full;
   assign DAHB_size       = hsize_q;
   assign DAHB_rd0_wr1    = we_q;
   assign DAHB_addr       = addr_q;
   assign DAHB_write_data = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dahb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_dahb_lsu
// Description : Table-driven bench for dahb_lsu: directed transactions with
//               hand-computed expectations, plus reset-state and
//               reset-during-load sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dahb_lsu;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [4:0]  mem_rd;
   logic        mem_stall;
   logic        misalign_exc;
   logic [31:0] exc_addr;
   logic        ld_wb_valid;
   logic [4:0]  ld_wb_rd;
   logic [31:0] ld_wb_data;
   logic        DAHB_access;
   logic [2:0]  DAHB_size;
   logic        DAHB_rd0_wr1;
   logic [31:0] DAHB_addr;
   logic [31:0] DAHB_write_data;
   logic        DAHB_trans_buffer_full;
   logic [31:0] DAHB_read_data;
   logic        DAHB_read_data_valid;

   int checks   = 0;
   int failures = 0;

   dahb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .cpu_clk                (cpu_clk),
      .cpu_rst                (cpu_rst),
      .mem_req                (mem_req),
      .mem_we                 (mem_we),
      .mem_size               (mem_size),
      .mem_unsigned           (mem_unsigned),
      .mem_addr               (mem_addr),
      .mem_wdata              (mem_wdata),
      .mem_rd                 (mem_rd),
      .mem_stall              (mem_stall),
      .misalign_exc           (misalign_exc),
      .exc_addr               (exc_addr),
      .ld_wb_valid            (ld_wb_valid),
      .ld_wb_rd               (ld_wb_rd),
      .ld_wb_data             (ld_wb_data),
      .DAHB_access            (DAHB_access),
      .DAHB_size              (DAHB_size),
      .DAHB_rd0_wr1           (DAHB_rd0_wr1),
      .DAHB_addr              (DAHB_addr),
      .DAHB_write_data        (DAHB_write_data),
      .DAHB_trans_buffer_full (DAHB_trans_buffer_full),
      .DAHB_read_data         (DAHB_read_data),
      .DAHB_read_data_valid   (DAHB_read_data_valid)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Read data must never coincide with the access that requested it.
   always @(negedge cpu_clk) begin
      if (DAHB_access && DAHB_read_data_valid) begin
         failures++;
         $display("FAIL access_rvalid_overlap actual=1 required=0");
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      int          full_cyc;
      logic [31:0] rdata;
      logic        exp_mis;
      logic [2:0]  exp_hsize;
      logic [31:0] exp_val;   // replicated store data or extended load result
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic set_vec(input int i, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int full_cyc, input logic [31:0] rdata, input logic exp_mis,
                          input logic [2:0] exp_hsize, input logic [31:0] exp_val);
      vecs[i].we = we;        vecs[i].size = size;       vecs[i].uns = uns;
      vecs[i].addr = addr;    vecs[i].wdata = wdata;     vecs[i].rd = rd;
      vecs[i].full_cyc = full_cyc; vecs[i].rdata = rdata; vecs[i].exp_mis = exp_mis;
      vecs[i].exp_hsize = exp_hsize; vecs[i].exp_val = exp_val;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_stall"},   {31'd0, mem_stall}, 32'd0);
      chk({tag, "_mis"},     {31'd0, misalign_exc}, 32'd0);
      chk({tag, "_ldv"},     {31'd0, ld_wb_valid}, 32'd0);
      chk({tag, "_access"},  {31'd0, DAHB_access}, 32'd0);
      chk({tag, "_wr"},      {31'd0, DAHB_rd0_wr1}, 32'd0);
      chk({tag, "_size"},    {29'd0, DAHB_size}, 32'd0);
      chk({tag, "_addr"},    DAHB_addr, 32'd0);
      chk({tag, "_wdata"},   DAHB_write_data, 32'd0);
      chk({tag, "_excaddr"}, exc_addr, 32'd0);
      chk({tag, "_lddata"},  ld_wb_data, 32'd0);
      chk({tag, "_ldrd"},    {27'd0, ld_wb_rd}, 32'd0);
   endtask

   // Called #1 after an edge with the DUT idle; returns in the same phase, idle.
   task automatic run_vec(input int i);
      string n;
      n = $sformatf("v%0d", i);
      chk({n, "_idle_stall"}, {31'd0, mem_stall}, 32'd0);
      mem_req = 1'b1;  mem_we = vecs[i].we;  mem_size = vecs[i].size;
      mem_unsigned = vecs[i].uns;  mem_addr = vecs[i].addr;
      mem_wdata = vecs[i].wdata;   mem_rd = vecs[i].rd;
      tick();                                  // now T+1
      mem_req = 1'b0;
      mem_wdata = 32'h0;
      if (vecs[i].exp_mis) begin
         chk({n, "_mis"},     {31'd0, misalign_exc}, 32'd1);
         chk({n, "_excaddr"}, exc_addr, vecs[i].addr);
         chk({n, "_noacc"},   {31'd0, DAHB_access}, 32'd0);
         chk({n, "_nostall"}, {31'd0, mem_stall}, 32'd0);
         tick();
         chk({n, "_mis_pulse"}, {31'd0, misalign_exc}, 32'd0);
         chk({n, "_excheld"},   exc_addr, vecs[i].addr);
         return;
      end
      for (int k = 0; k < vecs[i].full_cyc; k++) begin
         DAHB_trans_buffer_full = 1'b1;
         #1;
         chk({n, "_full_noacc"}, {31'd0, DAHB_access}, 32'd0);
         chk({n, "_full_stall"}, {31'd0, mem_stall}, 32'd1);
         tick();
      end
      DAHB_trans_buffer_full = 1'b0;
      #1;
      chk({n, "_acc"},   {31'd0, DAHB_access}, 32'd1);
      chk({n, "_stall"}, {31'd0, mem_stall}, 32'd1);
      chk({n, "_size"},  {29'd0, DAHB_size}, {29'd0, vecs[i].exp_hsize});
      chk({n, "_wr"},    {31'd0, DAHB_rd0_wr1}, {31'd0, vecs[i].we});
      chk({n, "_addr"},  DAHB_addr, vecs[i].addr);
      if (vecs[i].we) chk({n, "_wdata"}, DAHB_write_data, vecs[i].exp_val);
      tick();                                  // store: T+2, load: waiting
      chk({n, "_acc_once"}, {31'd0, DAHB_access}, 32'd0);
      if (vecs[i].we) begin
         chk({n, "_posted"}, {31'd0, mem_stall}, 32'd0);
         return;
      end
      tick();
      chk({n, "_wait_stall"}, {31'd0, mem_stall}, 32'd1);
      DAHB_read_data = vecs[i].rdata;
      DAHB_read_data_valid = 1'b1;
      tick();                                  // R+1
      DAHB_read_data_valid = 1'b0;
      DAHB_read_data = 32'hDEAD_0000;
      chk({n, "_ldv"},     {31'd0, ld_wb_valid}, 32'd1);
      chk({n, "_ldrd"},    {27'd0, ld_wb_rd}, {27'd0, vecs[i].rd});
      chk({n, "_lddata"},  ld_wb_data, vecs[i].exp_val);
      chk({n, "_ldstall"}, {31'd0, mem_stall}, 32'd0);
      tick();
      chk({n, "_ldv_pulse"}, {31'd0, ld_wb_valid}, 32'd0);
   endtask

   initial begin
      cpu_rst = 1'b1;
      mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
      mem_addr = 32'h0; mem_wdata = 32'h0; mem_rd = 5'd0;
      DAHB_trans_buffer_full = 1'b0; DAHB_read_data = 32'h0; DAHB_read_data_valid = 1'b0;

      //        i  we  size  uns addr          wdata         rd  full rdata         mis hsize   expected
      set_vec( 0, 1, 2'd0, 0, 32'h0000_1003, 32'h0000_00A5, 0,  0, 32'h0,         0, 3'b000, 32'hA5A5_A5A5);
      set_vec( 1, 0, 2'd1, 0, 32'h0000_2002, 32'h0,         5,  0, 32'h8001_1234, 0, 3'b001, 32'hFFFF_8001);
      set_vec( 2, 0, 2'd1, 1, 32'h0000_2002, 32'h0,         6,  0, 32'h8001_1234, 0, 3'b001, 32'h0000_8001);
      set_vec( 3, 0, 2'd0, 1, 32'h0000_3001, 32'h0,         7,  0, 32'h1122_3344, 0, 3'b000, 32'h0000_0033);
      set_vec( 4, 1, 2'd2, 0, 32'h0000_4000, 32'hDEAD_BEEF, 0,  5, 32'h0,         0, 3'b010, 32'hDEAD_BEEF);
      set_vec( 5, 0, 2'd2, 0, 32'h0000_5002, 32'h0,         8,  0, 32'h0,         1, 3'b010, 32'h0);
      set_vec( 6, 0, 2'd2, 0, 32'h0000_5004, 32'h0,         9,  0, 32'hCAFE_F00D, 0, 3'b010, 32'hCAFE_F00D);
      set_vec( 7, 1, 2'd1, 0, 32'h0000_6002, 32'h1234_ABCD, 0,  0, 32'h0,         0, 3'b001, 32'hABCD_ABCD);
      set_vec( 8, 0, 2'd0, 0, 32'h0000_7003, 32'h0,        31,  2, 32'h80FF_0011, 0, 3'b000, 32'hFFFF_FF80);
      set_vec( 9, 1, 2'd1, 0, 32'h0000_6001, 32'h0000_1111, 0,  0, 32'h0,         1, 3'b001, 32'h0);
      set_vec(10, 1, 2'd3, 0, 32'h0000_8000, 32'h1234_5678, 0,  0, 32'h0,         0, 3'b010, 32'h1234_5678);
      set_vec(11, 0, 2'd0, 0, 32'h0000_7000, 32'h0,         1,  0, 32'h0000_00FE, 0, 3'b000, 32'hFFFF_FFFE);
      set_vec(12, 0, 2'd1, 0, 32'h0000_2000, 32'h0,         2,  0, 32'hFFFF_7FFF, 0, 3'b001, 32'h0000_7FFF);
      set_vec(13, 1, 2'd0, 0, 32'h0000_9002, 32'h0000_5A3C, 0,  1, 32'h0,         0, 3'b000, 32'h3C3C_3C3C);

      tick();
      tick();
      check_reset_values("rst_hold");
      cpu_rst = 1'b0;
      tick();
      check_reset_values("rst_rel");

      for (int i = 0; i < NVEC; i++) run_vec(i);

      // Reset while waiting for load data; a later read-valid must be ignored.
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0;
      mem_addr = 32'h0000_A000; mem_rd = 5'd12;
      tick();
      mem_req = 1'b0;
      chk("mid_acc", {31'd0, DAHB_access}, 32'd1);
      tick();
      chk("mid_wait_stall", {31'd0, mem_stall}, 32'd1);
      cpu_rst = 1'b1;
      tick();
      chk("mid_rst_acc", {31'd0, DAHB_access}, 32'd0);
      cpu_rst = 1'b0;
      #1;
      chk("mid_after_acc", {31'd0, DAHB_access}, 32'd0);
      DAHB_read_data = 32'h1357_9BDF;
      DAHB_read_data_valid = 1'b1;
      tick();
      DAHB_read_data_valid = 1'b0;
      check_reset_values("mid_rst");
      tick();
      check_reset_values("mid_rst2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
